// File: rtl/bcd_channel_scheduler.sv
// Shares one combinational binary-to-BCD converter across N_CH sample channels.
// Samples are snapshotted, served round-robin, and results kept per channel for random-access reads.
module bcd_channel_scheduler #(
    parameter int N_CH   = 13,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [12*N_CH-1:0]   sample_data,
    input  logic [N_CH-1:0]      sample_valid,
    output logic [11:0]          bin,
    input  logic [3:0]           bcd0,
    input  logic [3:0]           bcd1,
    input  logic [3:0]           bcd2,
    input  logic [3:0]           bcd3,
    input  logic [3:0]           rd_ch,
    output logic [15:0]          rd_bcd,
    output logic                 conv_done,
    output logic [3:0]           conv_ch,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, WAIT, STORE} state_t;

    state_t                    state_q, state_d;
    logic [N_CH-1:0]           pending_q, pending_d;
    logic [N_CH-1:0][11:0]     snap_q, snap_d;
    logic [N_CH-1:0][15:0]     result_q, result_d;
    logic [11:0]               bin_q, bin_d;
    logic [3:0]                cur_q, cur_d;
    logic [3:0]                last_q, last_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [3:0]                conv_ch_q, conv_ch_d;

    logic                      grant_vld;
    logic [3:0]                grant_idx;
    logic [4:0]                arb_idx;

    // Walk from the farthest candidate back to last+1 so the nearest pending channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            arb_idx = {1'b0, last_q} + 5'(k);
            if (arb_idx >= 5'(N_CH)) arb_idx = arb_idx - 5'(N_CH);
            if (pending_q[arb_idx[3:0]]) begin
                grant_vld = 1'b1;
                grant_idx = arb_idx[3:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        result_d  = result_q;
        bin_d     = bin_q;
        cur_d     = cur_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        conv_ch_d = conv_ch_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    bin_d                = snap_q[grant_idx];
                    cur_d                = grant_idx;
                    last_d               = grant_idx;
                    pending_d[grant_idx] = 1'b0;
                    cnt_d                = 4'(SETTLE - 1);
                    state_d              = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = STORE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            STORE: begin
                result_d[cur_q] = {bcd3, bcd2, bcd1, bcd0};
                done_d          = 1'b1;
                conv_ch_d       = cur_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh strobe beats the grant's clear, so the channel is requeued with the new value.
        for (int i = 0; i < N_CH; i++) begin
            if (sample_valid[i]) begin
                pending_d[i] = 1'b1;
                snap_d[i]    = sample_data[12*i +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            snap_q    <= '0;
            result_q  <= '0;
            bin_q     <= '0;
            cur_q     <= '0;
            last_q    <= 4'(N_CH - 1);
            cnt_q     <= '0;
            done_q    <= 1'b0;
            conv_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            result_q  <= result_d;
            bin_q     <= bin_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            conv_ch_q <= conv_ch_d;
        end
    end

    always_comb begin
        rd_bcd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 4'(i)) rd_bcd = result_q[i];
        end
    end

    assign bin       = bin_q;
    assign conv_done = done_q;
    assign conv_ch   = conv_ch_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/bcd_channel_scheduler.md
Name: bcd_channel_scheduler

Overview:
Time-shares one combinational 12-bit binary-to-4-digit-BCD converter across N_CH voltage channels. Each channel's new ADC sample is snapshotted and marked pending. A round-robin arbiter then feeds one pending sample at a time to the converter, waits a settle interval and captures the four BCD digits into a per-channel result buffer. The display logic reads that buffer through a random-access read port.

Parameters:
N_CH, 13, number of channels (1..16)
SETTLE, 2, cycles the converter input is held before digits are captured (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_data  in  12*N_CH  channel i sample at bits [12*i+11:12*i]
sample_valid  in  N_CH  one-cycle strobe per channel; a new sample is present
bin  out  12  operand driven to the shared converter
bcd0  in  4  converter units digit
bcd1  in  4  converter tens digit
bcd2  in  4  converter hundreds digit
bcd3  in  4  converter thousands digit
rd_ch  in  4  read address (channel index)
rd_bcd  out  16  {bcd3,bcd2,bcd1,bcd0} stored for rd_ch
conv_done  out  1  one-cycle pulse; a result was just written
conv_ch  out  4  channel of the latest result (valid with conv_done, held afterwards)
busy  out  1  high when state is not IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - state IDLE; bin=0; conv_done=0; conv_ch=0; busy=0.
  - All pending flags, snapshots and result entries are 0.
  - Round-robin pointer last=N_CH-1, so channel 0 wins first.
- Reset mid-conversion: the conversion is abandoned; no result write and no conv_done.
- Snapshot: sample_valid[i] high at a clock edge sets snap[i] to sample_data[i] and pending[i] to 1. A later strobe before service overwrites snap[i]; only the newest value is converted.
- FSM states: IDLE, WAIT, STORE.
- IDLE:
  - If any pending flag is set (registered value), grant the first set channel searching last+1, last+2, ... with wrap at N_CH-1 back to 0.
  - On the edge: bin<=snap[g]; cur<=g; last<=g; pending[g]<=0; cnt<=SETTLE-1; state<=WAIT.
  - If none is pending, remain in IDLE and hold bin.
- WAIT: hold bin. If cnt==0, go to STORE; else cnt<=cnt-1. WAIT lasts exactly SETTLE cycles.
- STORE:
  - result[cur]<={bcd3,bcd2,bcd1,bcd0}; conv_done<=1 (high for the next cycle only); conv_ch<=cur; state<=IDLE.
- Simultaneous events:
  - sample_valid[g] in the same cycle as g is granted: the set wins. pending[g] stays 1 and snap[g] takes the new value. The in-flight conversion uses the previous snapshot, and g is requeued.
- Latency:
  - Strobe at cycle 0 with the scheduler idle gives: pending at cycle 1, WAIT from cycle 2, STORE at cycle SETTLE+2.
  - conv_done high and new rd_bcd visible at cycle SETTLE+3 (5 with defaults).
- Throughput: one conversion per SETTLE+2 cycles when requests are continuous.
- Read port:
  - rd_bcd is a combinational read of result[rd_ch].
  - rd_ch>=N_CH returns 16'h0000.
  - A read of cur during the write cycle returns the old value.
- Width rules:
  - 12-bit input maximum 4095, so bcd3 is at most 4.
  - Digits are stored unmodified; no range check is performed.

Test Plan:
- Reset, then strobe ch0 with 4095 at cycle 0; model the converter combinationally -> bin=4095 from cycle 2, conv_done at cycle 5 with conv_ch=0, rd_ch=0 gives 16'h4095, busy high during cycles 2-4.
- Strobe all 13 channels together with value 100*i+7 -> service order 0,1,...,12, conv_done every 4 cycles, each rd_bcd equals the BCD of 100*i+7 (ch12 -> 16'h1207).
- Fairness: after ch5 completes, strobe ch3 and ch7 together -> ch7 converted first, then ch3.
- Re-strobe ch2 with 123 in its grant cycle, then with 456 -> ch2 converted twice, final rd_bcd=16'h0456, no other channel starved.
- Assert rst during WAIT of a ch4 conversion -> no conv_done, rd_bcd=0 for all channels, the next strobe is served from channel 0 priority.
- rd_ch=13 and rd_ch=15 -> rd_bcd=16'h0000. Two back-to-back strobes on ch1 before its grant -> only the second value is converted.
